// File: rtl/spi_slave.sv
// Byte-oriented SPI responder (mode 0, MSB first) running in the clk domain.
// SCLK, CS and MOSI are oversampled; received bytes are strobed out on
// rx_valid, and transmit bytes come from a single-entry buffer.
module spi_slave #(
    parameter int unsigned              DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]    DEFAULT_TX = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int unsigned    CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_next;

    logic sclk_m, sclk_s, sclk_d;
    logic cs_m, cs_s, cs_d;
    logic mosi_m, mosi_s;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [CNT_W-1:0]      bit_cnt, bit_cnt_next;
    logic [DATA_WIDTH-1:0] tx_shift, tx_shift_next;
    logic [DATA_WIDTH-1:0] rx_shift, rx_shift_next;
    logic [DATA_WIDTH-1:0] tx_buf, tx_buf_next;
    logic [DATA_WIDTH-1:0] rx_data_next;
    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  tx_ready_next;
    logic                  miso_next, rx_valid_next, busy_next, frame_err_next;
    logic                  byte_start;

    // Two-flop synchronizers plus one delay stage for edge detection.
    // CS sync resets low so a CS still held low after reset is not seen as a
    // falling edge: the interrupted frame is dropped until the next CS fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_m <= 1'b0; sclk_s <= 1'b0; sclk_d <= 1'b0;
            cs_m   <= 1'b0; cs_s   <= 1'b0; cs_d   <= 1'b0;
            mosi_m <= 1'b0; mosi_s <= 1'b0;
        end else begin
            sclk_m <= sclk; sclk_s <= sclk_m; sclk_d <= sclk_s;
            cs_m   <= cs;   cs_s   <= cs_m;   cs_d   <= cs_s;
            mosi_m <= mosi; mosi_s <= mosi_m;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        tx_shift_next  = tx_shift;
        rx_shift_next  = rx_shift;
        tx_buf_next    = tx_buf;
        tx_ready_next  = tx_ready;
        rx_data_next   = rx_data;
        miso_next      = miso;
        rx_valid_next  = 1'b0;
        frame_err_next = 1'b0;
        byte_start     = 1'b0;
        rx_byte        = rx_shift;
        rx_byte[bit_cnt] = mosi_s;

        // A full buffer ignores further loads until a byte start drains it.
        if (tx_load && tx_ready) begin
            tx_buf_next   = tx_data;
            tx_ready_next = 1'b0;
        end

        case (state)
            IDLE: begin
                miso_next = 1'b0;
                if (cs_fall) begin
                    state_next = SHIFT;
                    byte_start = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    miso_next  = 1'b0;
                    if (bit_cnt != LAST_BIT) frame_err_next = 1'b1;
                end else if (sclk_rise) begin
                    miso_next = tx_shift[bit_cnt];
                end else if (sclk_fall) begin
                    rx_shift_next = rx_byte;
                    if (bit_cnt == '0) begin
                        rx_data_next  = rx_byte;
                        rx_valid_next = 1'b1;
                        byte_start    = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt - CNT_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Byte start: reload the shifter and present its MSB before SCLK rises.
        if (byte_start) begin
            bit_cnt_next = LAST_BIT;
            if (!tx_ready) begin
                tx_shift_next = tx_buf;
                tx_ready_next = 1'b1;
            end else begin
                tx_shift_next = DEFAULT_TX;
            end
            miso_next = tx_shift_next[DATA_WIDTH-1];
        end

        busy_next = (state_next == SHIFT);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= LAST_BIT;
            tx_shift  <= '0;
            rx_shift  <= '0;
            tx_buf    <= '0;
            tx_ready  <= 1'b1;
            rx_data   <= '0;
            miso      <= 1'b0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            bit_cnt   <= bit_cnt_next;
            tx_shift  <= tx_shift_next;
            rx_shift  <= rx_shift_next;
            tx_buf    <= tx_buf_next;
            tx_ready  <= tx_ready_next;
            rx_data   <= rx_data_next;
            miso      <= miso_next;
            rx_valid  <= rx_valid_next;
            busy      <= busy_next;
            frame_err <= frame_err_next;
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural SPI master at SCLK = clk/12.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk, cs, mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       frame_err;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         rxv_cnt  = 0;
    int         fe_cnt   = 0;
    logic [7:0] rx_hist[$];

    spi_slave #(.DATA_WIDTH(8), .DEFAULT_TX(8'h00)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Pulse monitors sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            rx_hist.push_back(rx_data);
        end
        if (frame_err) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
    endtask

    // Master shifts nbits MSB first: drive MOSI on rise, sample MISO before fall.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            tick(6);
            sclk = 1'b1;
            mosi = tx[i];
            tick(6);
            rx[i] = miso;
            sclk = 1'b0;
        end
    endtask

    task automatic frame1(input logic [7:0] tx, output logic [7:0] rx);
        cs = 1'b0;
        spi_bits(tx, 8, rx);
        tick(8);
        cs = 1'b1;
        tick(8);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] r, r1, r2;
        int         base, fe_base, waited;

        rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
        tx_data = 8'h00; tx_load = 1'b0;
        tick(3);
        check("rst_miso", miso, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_frame_err", frame_err, 0);
        rst = 1'b0;
        tick(4);

        // Single byte with buffered A5.
        load(8'hA5);
        tick(1);
        check("single_tx_ready_loaded", tx_ready, 0);
        base = rxv_cnt;
        cs = 1'b0;
        tick(6);
        check("single_busy", busy, 1);
        check("single_tx_ready_cs_fall", tx_ready, 1);
        spi_bits(8'h3C, 8, r);
        tick(8);
        cs = 1'b1;
        tick(8);
        check("single_master_rx", r, 8'hA5);
        check("single_rx_data", rx_data, 8'h3C);
        check("single_rx_valid_cnt", rxv_cnt - base, 1);
        check("single_busy_end", busy, 0);
        check("single_miso_end", miso, 0);
        check("single_no_ferr", fe_cnt, 0);

        // Empty buffer sends DEFAULT_TX.
        base = rxv_cnt;
        frame1(8'hFF, r);
        check("empty_master_rx", r, 8'h00);
        check("empty_rx_data", rx_data, 8'hFF);
        check("empty_rx_valid_cnt", rxv_cnt - base, 1);

        // Two bytes in one frame, second buffer loaded after first byte start.
        load(8'h11);
        base = rx_hist.size();
        fork
            begin
                cs = 1'b0;
                spi_bits(8'h81, 8, r1);
                spi_bits(8'h7E, 8, r2);
                tick(8);
                cs = 1'b1;
                tick(8);
            end
            begin
                waited = 0;
                while (!tx_ready && waited < 200) begin
                    tick(1);
                    waited++;
                end
                check("two_tx_ready_wait", tx_ready, 1);
                load(8'h22);
            end
        join
        check("two_master_rx0", r1, 8'h11);
        check("two_master_rx1", r2, 8'h22);
        check("two_rx_valid_cnt", rx_hist.size() - base, 2);
        if (rx_hist.size() - base == 2) begin
            check("two_rx_data0", rx_hist[base], 8'h81);
            check("two_rx_data1", rx_hist[base+1], 8'h7E);
        end

        // Abort after 5 bits.
        base = rxv_cnt;
        fe_base = fe_cnt;
        cs = 1'b0;
        spi_bits(8'hF0, 5, r);
        tick(8);
        cs = 1'b1;
        tick(8);
        check("abort_frame_err_cnt", fe_cnt - fe_base, 1);
        check("abort_no_rx_valid", rxv_cnt - base, 0);
        check("abort_rx_data_kept", rx_data, 8'h7E);
        check("abort_busy", busy, 0);
        check("abort_miso", miso, 0);
        frame1(8'h5A, r);
        check("after_abort_rx_data", rx_data, 8'h5A);
        check("after_abort_master_rx", r, 8'h00);
        check("after_abort_rx_valid_cnt", rxv_cnt - base, 1);

        // Overwrite attempt while buffer full is ignored.
        load(8'h55);
        load(8'hAA);
        check("ovr_tx_ready", tx_ready, 0);
        frame1(8'h00, r);
        check("ovr_master_rx", r, 8'h55);
        check("ovr_rx_data", rx_data, 8'h00);

        // Asynchronous reset mid-byte.
        load(8'h99);
        fe_base = fe_cnt;
        cs = 1'b0;
        spi_bits(8'hFF, 3, r);
        tick(2);
        rst = 1'b1;
        #1;
        check("mid_rst_busy_async", busy, 0);
        tick(1);
        check("mid_rst_miso", miso, 0);
        check("mid_rst_rx_data", rx_data, 8'h00);
        check("mid_rst_rx_valid", rx_valid, 0);
        check("mid_rst_tx_ready", tx_ready, 1);
        check("mid_rst_frame_err", frame_err, 0);
        rst = 1'b0;
        tick(6);
        check("post_rst_idle_busy", busy, 0);
        cs = 1'b1;
        tick(8);
        check("post_rst_no_ferr", fe_cnt - fe_base, 0);
        load(8'hC3);
        base = rxv_cnt;
        frame1(8'hC3, r);
        check("post_rst_master_rx", r, 8'hC3);
        check("post_rst_rx_data", rx_data, 8'hC3);
        check("post_rst_rx_valid_cnt", rxv_cnt - base, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

Byte-oriented SPI responder that pairs with the team's SPI master on the same bus: CS active-low, SCLK idles low, MSB first, 8 bits per byte. The master drives MOSI on SCLK rising edges and samples MISO on SCLK falling edges. This block oversamples SCLK, CS and MOSI in its own system-clock domain, returns a received byte with a one-cycle valid strobe, and shifts out a byte pre-loaded by local logic through a single-entry transmit buffer. Multiple back-to-back bytes within one CS-low frame are supported.

## Interface
- DATA_WIDTH, 8: bits per byte; the counter and shift registers are sized from it.
- DEFAULT_TX, 8'h00: byte shifted out when no transmit data is buffered at byte start.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock from master; asynchronous to clk.
- cs  input  1  chip select, active low; asynchronous to clk.
- mosi  input  1  serial data from master.
- miso  output  1  serial data to master; driven 0 whenever the synchronized CS is high.
- tx_data  input  DATA_WIDTH  byte to transmit.
- tx_load  input  1  write strobe; captures tx_data when tx_ready=1.
- tx_ready  output  1  transmit buffer empty.
- rx_data  output  DATA_WIDTH  last completed received byte; held until the next byte completes.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- busy  output  1  high while in state SHIFT.
- frame_err  output  1  one-cycle pulse when CS deasserts mid-byte.

## Operation
- Reset values: miso=0, rx_data=0, rx_valid=0, busy=0, tx_ready=1, frame_err=0, state=IDLE, bit_cnt=DATA_WIDTH-1, tx buffer empty.
- Synchronization: sclk, cs and mosi each pass through a 2-flop synchronizer. One further register per signal provides edge detection. Edges are detected on the synchronized signals only.
- IDLE: busy=0, miso=0. A CS falling edge moves the block to SHIFT and performs a byte start.
- Byte start:
  - bit_cnt set to DATA_WIDTH-1.
  - tx_shift loaded from the buffer if it is full; the buffer then empties and tx_ready rises.
  - Otherwise tx_shift is loaded with DEFAULT_TX.
  - miso is set to tx_shift MSB, so it is valid before the first rising edge.
- SHIFT, SCLK rising edge: miso is driven with tx_shift[bit_cnt]. This is idempotent for the first bit and yields the next bit on later edges.
- SHIFT, SCLK falling edge:
  - rx_shift[bit_cnt] is set to the synchronized mosi.
  - If bit_cnt==0: rx_data is set to the full byte, rx_valid pulses, and a byte start occurs (continuation within the frame).
  - Otherwise bit_cnt decrements.
  - The first MISO bit of the new byte is therefore set at its byte start.
- CS rising edge in SHIFT: return to IDLE and set miso to 0.
  - If bit_cnt != DATA_WIDTH-1 (partial byte), pulse frame_err and discard rx_shift; rx_data and rx_valid are untouched.
  - CS rising takes priority over a simultaneous SCLK edge.
- Transmit buffer:
  - tx_load with tx_ready=1 captures tx_data and clears tx_ready next cycle.
  - tx_load with tx_ready=0 is ignored; the buffered byte is kept.
  - tx_load in the same cycle as a byte start with an empty buffer fills the buffer for the next byte. It is not bypassed into the current byte, which sends DEFAULT_TX.
  - The buffer is loadable in any state. A byte consumed at byte start is not restored on frame_err.
- SCLK edges while in IDLE are ignored.

## Timing
- Detection latency: an SCLK or CS edge at the pins is acted upon 3 clk cycles later, plus up to 1 cycle of sampling uncertainty.
- rx_valid rises 1 cycle after the detected final falling edge of a byte, i.e. 4-5 clk cycles after the pin edge.
- miso changes 1 clk after edge detection.
- SCLK high and low phases must each be at least 6 clk cycles.
- CS setup to the first SCLK rise must be at least 6 clk cycles.
- Faster SCLK is outside the operating range; behaviour is unspecified but the block must recover after the next CS rise.
- Reset mid-frame: all state returns to reset values immediately. The block resumes on the next CS falling edge; the current frame is lost.

## Test plan
- Single byte: buffer 8'hA5, master sends 8'h3C at SCLK = clk/12 -> master receives 8'hA5; rx_data=8'h3C with exactly one rx_valid pulse; tx_ready returns to 1 at CS fall.
- Empty buffer: no tx_load, master sends 8'hFF -> master receives 8'h00 (DEFAULT_TX); rx_data=8'hFF.
- Two bytes in one CS-low frame: buffer 8'h11, then load 8'h22 after the first byte start; master sends 8'h81, 8'h7E -> master receives 8'h11, 8'h22; two rx_valid pulses with rx_data 8'h81 then 8'h7E.
- Abort: CS rises after 5 bits -> frame_err pulses once, no rx_valid, rx_data keeps its previous value, busy falls, miso=0; the next full frame is received correctly.
- Buffer overwrite: tx_load 8'h55 then tx_load 8'hAA while tx_ready=0 -> master receives 8'h55.
- Async reset asserted mid-byte -> all outputs at reset values on the next edge; a subsequent frame transfers 8'hC3 both ways correctly.
